// File: rtl/fb_scanout_arbiter_if.sv
// rtl/fb_scanout_arbiter_if.sv - CPU load/store bus into the framebuffer arbiter
interface fb_scanout_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [16:0] cpu_addr;
  logic [11:0] cpu_wdata;
  logic [11:0] cpu_rdata;
  logic        cpu_ack;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/fb_scanout_arbiter.sv
// rtl/fb_scanout_arbiter.sv - framebuffer RAM arbiter, line-buffer fill vs CPU, 2x scanout (option: FB_CPU_SLOT_EN)
module fb_scanout_arbiter #(
  parameter int SRC_W    = 320,
  parameter int SRC_H    = 240,
  parameter int V_PIXELS = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      line_start,
  input  logic [9:0]                line_num,
  input  logic [9:0]                pix_x,
  input  logic [9:0]                pix_y,
  output logic [3:0]                color_r,
  output logic [3:0]                color_g,
  output logic [3:0]                color_b,
  fb_scanout_arbiter_if.slave       cpu,
  output logic [16:0]               mem_addr,
  output logic                      mem_we,
  output logic [11:0]               mem_wdata,
  input  logic [11:0]               mem_rdata
);

  localparam logic [16:0] FB_SIZE   = 17'(SRC_W * SRC_H);
  localparam logic [9:0]  LAST_LINE = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VIS_LINES = 10'(V_PIXELS);
  localparam logic [8:0]  ROW_LEN   = 9'(SRC_W);

  typedef enum logic [1:0] {IDLE, FILL, CPU, ACK} state_t;
  state_t state, state_nxt;

  logic [11:0] line_buf [2][SRC_W];
  logic        pending;
  logic [7:0]  pend_row;
  logic        fill_bank;
  logic [16:0] fill_base;
  logic [8:0]  fill_idx;
  logic        fill_cap;
  logic [8:0]  cap_idx;
  logic        fill_paused;
  logic        op_we;
  logic        op_oor;
  logic [11:0] rdata_q;

  logic [9:0]  next_line;
  logic        trig;
  logic        cpu_oor;
  logic        slot_open;
  logic        issue;
  logic        start_fill;
  logic        take_cpu;
  logic        yield;
  logic [11:0] pixel;
  logic        unused_bits;

  assign unused_bits = ^{pix_x[0], pix_y[0], pix_y[9:2]};

  // Decode which source row (if any) the upcoming display line needs buffered
  always_comb begin
    next_line = (line_num == LAST_LINE) ? 10'd0 : line_num + 10'd1;
    trig      = line_start && (next_line < VIS_LINES) && !next_line[0];
    cpu_oor   = cpu.cpu_addr >= FB_SIZE;
  end

`ifdef FB_CPU_SLOT_EN
  // Every fourth fill slot may be lent to a waiting CPU access, once per index
  assign slot_open = (fill_idx[1:0] == 2'b11) && !fill_paused;
`else
  assign slot_open = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and RAM port drive
  always_comb begin
    state_nxt  = state;
    mem_addr   = 17'd0;
    mem_we     = 1'b0;
    mem_wdata  = 12'd0;
    issue      = 1'b0;
    start_fill = 1'b0;
    take_cpu   = 1'b0;
    yield      = 1'b0;
    case (state)
      IDLE: begin
        if (pending) begin
          start_fill = 1'b1;
          state_nxt  = FILL;
        end else if (cpu.cpu_req) begin
          take_cpu  = 1'b1;
          state_nxt = cpu_oor ? ACK : CPU;
        end
      end
      FILL: begin
        if (fill_idx == ROW_LEN) begin
          state_nxt = IDLE;
        end else if (slot_open && cpu.cpu_req) begin
          take_cpu  = 1'b1;
          yield     = 1'b1;
          state_nxt = cpu_oor ? ACK : CPU;
        end else begin
          issue    = 1'b1;
          mem_addr = fill_base + 17'(fill_idx);
        end
      end
      CPU: begin
        mem_addr  = cpu.cpu_addr;
        mem_we    = cpu.cpu_we;
        mem_wdata = cpu.cpu_wdata;
        state_nxt = ACK;
      end
      ACK: begin
        if (fill_paused) begin
          state_nxt = FILL;
        end else if (pending) begin
          start_fill = 1'b1;
          state_nxt  = FILL;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fill bookkeeping, latched trigger and CPU operation capture
  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= 1'b0;
      pend_row    <= 8'd0;
      fill_bank   <= 1'b0;
      fill_base   <= 17'd0;
      fill_idx    <= 9'd0;
      fill_cap    <= 1'b0;
      cap_idx     <= 9'd0;
      fill_paused <= 1'b0;
      op_we       <= 1'b0;
      op_oor      <= 1'b0;
      rdata_q     <= 12'd0;
    end else begin
      fill_cap <= issue;
      cap_idx  <= fill_idx;
      if (start_fill) begin
        pending     <= 1'b0;
        fill_bank   <= pend_row[0];
        fill_base   <= 17'(pend_row) * 17'(SRC_W);
        fill_idx    <= 9'd0;
        fill_paused <= 1'b0;
      end
      // a new trigger wins over the clear of the one being started
      if (trig) begin
        pending  <= 1'b1;
        pend_row <= next_line[8:1];
      end
      if (issue) begin
        fill_idx    <= fill_idx + 9'd1;
        fill_paused <= 1'b0;
      end
      if (yield) fill_paused <= 1'b1;
      if (take_cpu) begin
        op_we  <= cpu.cpu_we;
        op_oor <= cpu_oor;
      end
      if (state == ACK) rdata_q <= cpu.cpu_rdata;
    end
  end

  // Line buffers: cleared on reset, loaded one cycle after each fill read
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < SRC_W; i++)
          line_buf[b][i] <= 12'd0;
    end else if (fill_cap) begin
      line_buf[fill_bank][cap_idx] <= mem_rdata;
    end
  end

  // Pixel-doubled scanout lookup
  always_comb begin
    pixel = line_buf[pix_y[1]][pix_x[9:1]];
    {color_r, color_g, color_b} = pixel;
  end

  assign cpu.cpu_ack   = (state == ACK);
  assign cpu.cpu_rdata = (state == ACK && !op_we) ? (op_oor ? 12'd0 : mem_rdata) : rdata_q;

endmodule

// File: doc/fb_scanout_arbiter.md
Name: fb_scanout_arbiter

Overview:
- Shares one single-port 320x240x12-bit framebuffer RAM between CPU load/store requests and VGA scanout.
- Scanout runs 2x pixel-doubled (640x480) from two ping-pong line buffers of 320 entries each.
- The buffer for the next source row is filled during the preceding display line; CPU accesses use the remaining memory cycles.
- Sits between the CPU bus, the framebuffer RAM and the 640x480@60 VGA timing generator, and supplies its pixel colour.

Parameters:
SRC_W, 320, source row width in pixels
SRC_H, 240, source row count
V_PIXELS, 480, visible display lines
V_TOTAL, 525, total lines per frame incl. blanking

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
line_start  in  1  one-cycle pulse at h_count==0 of every line (800-cycle period)
line_num  in  10  current v_count, 0..524, valid when line_start=1
pix_x  in  10  visible x, 0..639
pix_y  in  10  visible y, 0..479
color_r/color_g/color_b  out  4 each  pixel colour for (pix_x,pix_y), combinational
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  17  pixel index y*320+x, 0..76799
cpu_wdata  in  12  {r,g,b}
cpu_rdata  out  12  read data, valid with cpu_ack
cpu_ack  out  1  one-cycle completion pulse
mem_addr  out  17  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  12  RAM write data
mem_rdata  in  12  RAM read data, 1-cycle latency after mem_addr

Behaviour:
- Reset: FSM=IDLE; cpu_ack=0; cpu_rdata=0; mem_we=0; mem_addr=0; fill counters=0; both line buffers cleared to 0; colour outputs driven from buffers (all 0).
- Fill trigger: on line_start, next = (line_num==V_TOTAL-1) ? 0 : line_num+1. If next<V_PIXELS and next even: start filling source row r=next>>1 into bank r[0].
- Display reads bank (pix_y>>1)[0] at index pix_x>>1. Bank being filled is never the bank being displayed.
- FSM:
  - IDLE: pending trigger -> FILL (priority); else cpu_req -> CPU.
  - FILL: issue mem_addr=r*320+i for i=0..319, one per cycle, mem_we=0. Write mem_rdata into buffer[i-1] one cycle later. After the final read's data is captured (321 cycles) -> IDLE.
  - CPU: drive cpu_addr/cpu_we/cpu_wdata for 1 cycle; next cycle pulse cpu_ack, cpu_rdata=mem_rdata on reads (writes: cpu_rdata holds previous value) -> IDLE. CPU occupies 2 cycles total.
- CPU must deassert or change cpu_req after ack. A req still high on the cycle after ack is treated as a new request.
- Trigger arriving during CPU: latched; FILL starts immediately after ack. CPU access never aborted.
- Trigger arriving during FILL: cannot occur (321 < 800). If it does, it is latched and served after the current fill.
- cpu_req during FILL: stalls; no ack until FILL ends. Max CPU latency 323 cycles.
- cpu_addr >= 76800: no RAM access (mem_we=0); ack after 1 cycle; cpu_rdata=0.
- Reset mid-fill or mid-CPU: abort immediately, no ack, return to reset state. Source row 0 is filled on line 524 of the next frame.
- Row 239 fills during line 477. No trigger fires for next = 480..524.

Optional Feature:
FB_CPU_SLOT_EN:
- Defined: during FILL, every 4th fill cycle (i%4==3 before issue) is yielded to a pending CPU access. The fill pauses, CPU access completes, fill resumes at the same i. Worst-case fill ~480 cycles; CPU latency <= 8 cycles.
- Undefined: CPU fully blocked during FILL as above.

Test Plan:
- Reset, then line_start with line_num=524; RAM row 0 = pixel index -> after 321 cycles bank0[i]=i[11:0]; pix_y=0/1, pix_x=10 or 11 -> colour = 5.
- cpu_req write addr=641 (row 2, x=1), data 0xABC, then line_start line_num=3 -> row 2 filled into bank0; pix_y=4, pix_x=2..3 -> colour 0xA/0xB/0xC.
- cpu_req read asserted 1 cycle after fill start -> cpu_ack exactly 322 cycles later with correct data (macro off); <=8 cycles (FB_CPU_SLOT_EN).
- line_start line_num=478 -> no fill; mem_addr idle; a CPU read acks in 2 cycles.
- reset asserted at fill index 100 -> no mem access next cycle, cpu_ack=0, buffers read 0.
- cpu_addr=76800 read -> ack after 1 cycle, cpu_rdata=0, mem_we=0.
